watch_core_param: RTL and testbench

Parametrised second-generation timekeeping core for the multi-function watch.
- Keeps sec/min/hour and runs from a configurable clock divider.
- In SET mode the selected field is edited with both increment and decrement.
- Provides a 12/24-hour display conversion and an hh:mm alarm with a timed output.
- Takes single-cycle pulse inputs; the upstream button edge-detect blocks supply them.

---
 rtl/watch_core_param.sv | 117 +++++++++++
 tb/tb_watch_core_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_core_param.sv
// watch_core_param: hh:mm:ss timekeeper with SET-mode field editing,
// 12/24-hour display conversion and an hh:mm alarm held for ALARM_LEN ticks.
module watch_core_param #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int CNT_W       = 27,
  parameter int ALARM_LEN   = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       mode_pulse,
  input  logic       sel_pulse,
  input  logic       up_pulse,
  input  logic       down_pulse,
  input  logic       clear_pulse,
  input  logic       mode_12h,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [7:0] disp_hour,
  output logic       pm,
  output logic       set_mode,
  output logic [1:0] field_sel,
  output logic       tick,
  output logic       alarm
);
  typedef enum logic {RUN, SET} state_t;
  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [7:0]       r_sec, r_min, r_hour, w_sec, w_min, w_hour, r_acnt, w_acnt;
  logic [1:0]       r_fsel, w_fsel;
  logic             r_tick, w_tick, r_alarm, w_alarm, w_wrap, w_edit, w_clr, w_hit;

  function automatic logic [7:0] f_step(input logic [7:0] v, input logic [7:0] mx, input logic inc);
    return inc ? (v == mx ? 8'd0 : v + 8'd1) : (v == 8'd0 ? mx : v - 8'd1);
  endfunction

  assign w_wrap = r_state == RUN && r_cnt == CNT_W'(TICK_CYCLES - 1);
  assign w_clr  = r_state == SET && clear_pulse;
  assign w_edit = r_state == SET && !clear_pulse && (up_pulse ^ down_pulse);

  always_comb begin
    w_state = mode_pulse ? (r_state == RUN ? SET : RUN) : r_state;
    w_cnt   = (r_state == RUN && !w_wrap) ? r_cnt + 1'b1 : '0;
    w_tick  = w_wrap;
    w_sec   = r_sec;
    w_min   = r_min;
    w_hour  = r_hour;
    w_fsel  = r_fsel;
    if (w_wrap) begin
      w_sec  = f_step(r_sec, 8'd59, 1'b1);
      w_min  = r_sec == 8'd59 ? f_step(r_min, 8'd59, 1'b1) : r_min;
      w_hour = (r_sec == 8'd59 && r_min == 8'd59) ? f_step(r_hour, 8'd23, 1'b1) : r_hour;
    end
    if (w_clr) begin
      w_sec  = '0;
      w_min  = '0;
      w_hour = '0;
    end
    // edits wrap inside the selected field only, never carrying
    if (w_edit) begin
      w_sec  = r_fsel == 2'd0 ? f_step(r_sec, 8'd59, up_pulse) : r_sec;
      w_min  = r_fsel == 2'd1 ? f_step(r_min, 8'd59, up_pulse) : r_min;
      w_hour = r_fsel == 2'd2 ? f_step(r_hour, 8'd23, up_pulse) : r_hour;
    end
    if (r_state == SET && sel_pulse) w_fsel = r_fsel == 2'd2 ? 2'd0 : r_fsel + 2'd1;
    w_hit   = w_wrap && alarm_en && w_sec == 8'd0 && w_min == alarm_min && w_hour == alarm_hour;
    w_alarm = r_alarm;
    w_acnt  = r_acnt;
    if (!alarm_en || mode_pulse) begin
      w_alarm = 1'b0;
      w_acnt  = '0;
    end else if (w_hit) begin
      w_alarm = 1'b1;
      w_acnt  = 8'(ALARM_LEN);
    end else if (w_wrap && r_alarm) begin
      w_acnt  = r_acnt - 8'd1;
      w_alarm = r_acnt != 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_sec   <= '0;
      r_min   <= '0;
      r_hour  <= '0;
      r_fsel  <= '0;
      r_tick  <= 1'b0;
      r_alarm <= 1'b0;
      r_acnt  <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sec   <= w_sec;
      r_min   <= w_min;
      r_hour  <= w_hour;
      r_fsel  <= w_fsel;
      r_tick  <= w_tick;
      r_alarm <= w_alarm;
      r_acnt  <= w_acnt;
    end
  end

  assign sec       = r_sec;
  assign min       = r_min;
  assign hour      = r_hour;
  assign set_mode  = r_state == SET;
  assign field_sel = r_fsel;
  assign tick      = r_tick;
  assign alarm     = r_alarm;
  assign pm        = r_hour >= 8'd12;
  assign disp_hour = !mode_12h ? r_hour : r_hour == 8'd0 ? 8'd12 : r_hour > 8'd12 ? r_hour - 8'd12 : r_hour;
endmodule

// File: tb/tb_watch_core_param.sv
// tb_watch_core_param: directed, table-driven and random checks of watch_core_param
// against a seconds-of-day reference model.
module tb_watch_core_param;
  localparam int T  = 4;
  localparam int AL = 3;

  logic       clk = 0, reset_p = 1, mode_pulse = 0, sel_pulse = 0, up_pulse = 0;
  logic       down_pulse = 0, clear_pulse = 0, mode_12h = 0, alarm_en = 1;
  logic [7:0] alarm_hour = 8'd30, alarm_min = 8'd0;
  logic [7:0] sec, min, hour, disp_hour;
  logic       pm, set_mode, tick, alarm;
  logic [1:0] field_sel;

  watch_core_param #(.TICK_CYCLES(T), .CNT_W(3), .ALARM_LEN(AL)) dut (
    .clk(clk), .reset_p(reset_p), .mode_pulse(mode_pulse), .sel_pulse(sel_pulse),
    .up_pulse(up_pulse), .down_pulse(down_pulse), .clear_pulse(clear_pulse),
    .mode_12h(mode_12h), .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .sec(sec), .min(min), .hour(hour), .disp_hour(disp_hour), .pm(pm), .set_mode(set_mode),
    .field_sel(field_sel), .tick(tick), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0, n_bad = 0;
  int   m_t = 0, m_f = 0, m_run = 0, m_rem = 0;
  logic m_set = 0, m_tick = 0;

  typedef struct {int h; logic m12; int disp; logic pm;} vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step;
    int s, mi, h;
    logic tk;
    if (reset_p) begin
      m_t = 0; m_f = 0; m_run = 0; m_rem = 0; m_set = 0; m_tick = 0;
      return;
    end
    tk = 0;
    if (!m_set) begin
      m_run++;
      tk = (m_run % T) == 0;
      if (tk) m_t = (m_t + 1) % 86400;
    end else begin
      m_run = 0;
      s = m_t % 60; mi = (m_t / 60) % 60; h = m_t / 3600;
      if (clear_pulse) begin s = 0; mi = 0; h = 0; end
      else if (up_pulse != down_pulse) begin
        if (m_f == 0) s = (s + (up_pulse ? 1 : 59)) % 60;
        else if (m_f == 1) mi = (mi + (up_pulse ? 1 : 59)) % 60;
        else h = (h + (up_pulse ? 1 : 23)) % 24;
      end
      m_t = h * 3600 + mi * 60 + s;
      if (sel_pulse) m_f = (m_f + 1) % 3;
    end
    if (mode_pulse) m_set = !m_set;
    if (!alarm_en || mode_pulse) m_rem = 0;
    else if (tk && int'(alarm_hour) < 24 && int'(alarm_min) < 60 &&
             m_t == int'(alarm_hour) * 3600 + int'(alarm_min) * 60) m_rem = AL;
    else if (tk && m_rem > 0) m_rem--;
    m_tick = tk;
  endtask

  task automatic check_all;
    int h;
    h = m_t / 3600;
    chk("sec", sec, m_t % 60);
    chk("min", min, (m_t / 60) % 60);
    chk("hour", hour, h);
    chk("disp_hour", disp_hour, mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h);
    chk("pm", pm, h >= 12);
    chk("set_mode", set_mode, m_set);
    chk("field_sel", field_sel, m_f);
    chk("tick", tick, m_tick);
    chk("alarm", alarm, m_rem > 0);
  endtask

  task automatic cyc;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic p_mode;  mode_pulse = 1;  cyc(); mode_pulse = 0;  endtask
  task automatic p_sel;   sel_pulse = 1;   cyc(); sel_pulse = 0;   endtask
  task automatic p_up;    up_pulse = 1;    cyc(); up_pulse = 0;    endtask
  task automatic p_down;  down_pulse = 1;  cyc(); down_pulse = 0;  endtask
  task automatic p_clear; clear_pulse = 1; cyc(); clear_pulse = 0; endtask
  task automatic enter_set; if (!m_set) p_mode(); endtask
  task automatic enter_run; if (m_set) p_mode(); endtask

  task automatic goto_field(input int f);
    for (int k = 0; k < 3 && m_f != f; k++) p_sel();
  endtask

  task automatic set_time(input int h, input int mi, input int s);
    p_clear();
    goto_field(2);
    if (h > 12) repeat (24 - h) p_down(); else repeat (h) p_up();
    goto_field(1);
    if (mi > 30) repeat (60 - mi) p_down(); else repeat (mi) p_up();
    goto_field(0);
    if (s > 30) repeat (60 - s) p_down(); else repeat (s) p_up();
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int last, nt, w;
    tbl[0] = '{0, 1, 12, 0};
    tbl[1] = '{11, 1, 11, 0};
    tbl[2] = '{12, 1, 12, 1};
    tbl[3] = '{13, 1, 1, 1};
    tbl[4] = '{23, 1, 11, 1};
    tbl[5] = '{13, 0, 13, 1};
    tbl[6] = '{0, 0, 0, 0};

    // reset and free run: 60 ticks in 240 cycles
    cyc();
    chk("rst_sec", sec, 0);
    chk("rst_set_mode", set_mode, 0);
    chk("rst_tick", tick, 0);
    reset_p = 0;
    last = -1; nt = 0;
    for (int i = 1; i <= 240; i++) begin
      cyc();
      if (tick) begin
        nt++;
        if (last >= 0) chk("tick_gap", i - last, T);
        last = i;
      end
    end
    chk("tick_count", nt, 60);
    chk("run_sec", sec, 0);
    chk("run_min", min, 1);
    chk("run_hour", hour, 0);

    // day rollover from 23:59:58
    enter_set();
    set_time(23, 59, 58);
    chk("pre_hour", hour, 23);
    chk("pre_min", min, 59);
    chk("pre_sec", sec, 58);
    chk("pre_pm", pm, 1);
    enter_run();
    repeat (8) cyc();
    chk("roll_hour", hour, 0);
    chk("roll_min", min, 0);
    chk("roll_sec", sec, 0);
    chk("roll_pm", pm, 0);

    // SET-mode edit priorities
    enter_set();
    goto_field(0);
    p_down();
    chk("dec_wrap", sec, 59);
    up_pulse = 1; down_pulse = 1; cyc(); up_pulse = 0; down_pulse = 0;
    chk("up_down_hold", sec, 59);
    goto_field(1); p_up(); goto_field(0);
    clear_pulse = 1; up_pulse = 1; cyc(); clear_pulse = 0; up_pulse = 0;
    chk("clr_sec", sec, 0);
    chk("clr_min", min, 0);
    sel_pulse = 1; up_pulse = 1; cyc(); sel_pulse = 0; up_pulse = 0;
    chk("sel_up_sec", sec, 1);
    chk("sel_up_field", field_sel, 1);

    // 12/24-hour display table
    foreach (tbl[i]) begin
      set_time(tbl[i].h, 0, 0);
      mode_12h = tbl[i].m12;
      cyc();
      chk("tbl_disp", disp_hour, tbl[i].disp);
      chk("tbl_pm", pm, tbl[i].pm);
    end
    mode_12h = 0;

    // alarm 00:01 runs 3 ticks, then acknowledge by mode_pulse
    alarm_hour = 0; alarm_min = 1; alarm_en = 1;
    set_time(0, 0, 58);
    enter_run();
    for (int i = 1; i <= 24; i++) begin
      cyc();
      chk("alarm_seq", alarm, i >= 8 && i < 20);
    end
    enter_set();
    set_time(0, 0, 58);
    enter_run();
    repeat (12) cyc();
    chk("ack_pre_alarm", alarm, 1);
    chk("ack_pre_sec", sec, 1);
    p_mode();
    chk("ack_alarm", alarm, 0);
    chk("ack_set_mode", set_mode, 1);

    // reset mid-count with alarm high
    set_time(12, 33, 58);
    p_sel();
    alarm_hour = 12; alarm_min = 34;
    enter_run();
    repeat (14) cyc();
    chk("mid_alarm", alarm, 1);
    chk("mid_min", min, 34);
    reset_p = 1; cyc(); reset_p = 0;
    chk("mr_sec", sec, 0);
    chk("mr_min", min, 0);
    chk("mr_hour", hour, 0);
    chk("mr_set_mode", set_mode, 0);
    chk("mr_field", field_sel, 0);
    chk("mr_alarm", alarm, 0);
    chk("mr_tick", tick, 0);
    w = 0;
    do begin cyc(); w++; end while (!tick && w < 20);
    chk("mr_first_tick", w, T);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) begin
        alarm_hour = 8'(m_t / 3600);
        alarm_min  = 8'(((m_t / 60) % 60 + 1) % 60);
        if ($urandom_range(7) == 0) alarm_hour = 8'($urandom_range(24, 255));
      end
      mode_pulse  = $urandom_range(59) == 0;
      sel_pulse   = $urandom_range(7) == 0;
      up_pulse    = $urandom_range(3) == 0;
      down_pulse  = $urandom_range(3) == 0;
      clear_pulse = $urandom_range(29) == 0;
      mode_12h    = 1'($urandom_range(1));
      alarm_en    = $urandom_range(63) != 0;
      reset_p     = $urandom_range(999) == 0;
      cyc();
      {mode_pulse, sel_pulse, up_pulse, down_pulse, clear_pulse, reset_p} = '0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
